// File: rtl/disp_arb_pkg.sv
// Shared types and widths for the six-digit display arbiter.
// The hold-time preemption feature is enabled by defining DISP_ARB_PREEMPT_EN.
package disp_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } state_e;

    localparam int SEG_W  = 42;
    localparam int DP_W   = 6;
    localparam int HOLD_W = 8;
    localparam int GAP_W  = 4;

endpackage

// File: rtl/disp_arb_rr_pick.sv
// Combinational round-robin picker: one-hot grant to the first requester at or
// above ptr, wrapping, plus a valid flag when any request is present.
module disp_arb_rr_pick #(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          valid
);

    localparam int SW = PW + 1;

    logic [SW-1:0] idx;
    logic          found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            // One spare bit keeps ptr+i from overflowing before the wrap
            idx = {1'b0, ptr} + SW'(i);
            if (idx >= SW'(N)) begin
                idx = idx - SW'(N);
            end
            if (!found && req[idx[PW-1:0]]) begin
                gnt[idx[PW-1:0]] = 1'b1;
                found            = 1'b1;
            end
        end
    end

    assign valid = found;

endmodule

// File: rtl/disp_arb.sv
// Round-robin owner of the six-digit display with a blank gap between owners.
// Define DISP_ARB_PREEMPT_EN to revoke an owner that has held MAX_HOLD ticks while others wait.
module disp_arb
    import disp_arb_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int MAX_HOLD   = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_tick,
    input  logic [NUM_REQ-1:0]       i_req,
    input  logic [NUM_REQ*SEG_W-1:0] i_seg_bus,
    input  logic [NUM_REQ*DP_W-1:0]  i_dp_bus,
    output logic [NUM_REQ-1:0]       o_gnt,
    output logic [SEG_W-1:0]         o_six_digit_seg,
    output logic [DP_W-1:0]          o_six_dp,
    output logic                     o_busy,
    output state_e                   o_dbg_state
);

    localparam int PTR_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_HOLD < 1 || MAX_HOLD > 255 ||
        GAP_CYCLES < 1 || GAP_CYCLES > 15) begin : g_param_check
        $error("disp_arb: parameter out of range");
    end

    state_e               state_q, state_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [SEG_W-1:0]     seg_q, seg_d;
    logic [DP_W-1:0]      dp_q, dp_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
`ifdef DISP_ARB_PREEMPT_EN
    logic [HOLD_W-1:0]    hold_q, hold_d;
`endif

    logic [NUM_REQ-1:0]   pick_gnt;
    logic                 pick_valid;
    logic [PTR_W-1:0]     owner_idx;
    logic [SEG_W-1:0]     own_seg;
    logic [DP_W-1:0]      own_dp;
    logic                 revoke;

    disp_arb_rr_pick #(
        .N  (NUM_REQ),
        .PW (PTR_W)
    ) u_rr_pick (
        .req   (i_req),
        .ptr   (ptr_q),
        .gnt   (pick_gnt),
        .valid (pick_valid)
    );

    // Owner's slice and index come straight from the one-hot grant register
    always_comb begin
        owner_idx = '0;
        own_seg   = '0;
        own_dp    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt_q[k]) begin
                owner_idx = PTR_W'(k);
                own_seg   = i_seg_bus[k*SEG_W +: SEG_W];
                own_dp    = i_dp_bus[k*DP_W +: DP_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        seg_d   = '0;
        dp_d    = '0;
        gap_d   = gap_q;
        revoke  = 1'b0;
`ifdef DISP_ARB_PREEMPT_EN
        hold_d  = hold_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = OWN;
                    gnt_d   = pick_gnt;
`ifdef DISP_ARB_PREEMPT_EN
                    hold_d  = '0;
`endif
                end
            end
            OWN: begin
                revoke = ~|(i_req & gnt_q);
`ifdef DISP_ARB_PREEMPT_EN
                if (hold_q == HOLD_W'(MAX_HOLD) && |(i_req & ~gnt_q)) begin
                    revoke = 1'b1;
                end
`endif
                if (revoke) begin
                    // Release and preemption share this single exit path
                    state_d = GAP;
                    gnt_d   = '0;
                    gap_d   = '0;
                    ptr_d   = (owner_idx == PTR_W'(NUM_REQ - 1)) ? '0 : owner_idx + PTR_W'(1);
                end else begin
                    seg_d = own_seg;
                    dp_d  = own_dp;
`ifdef DISP_ARB_PREEMPT_EN
                    if (i_tick && hold_q != HOLD_W'(MAX_HOLD)) begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
`endif
                end
            end
            GAP: begin
                gap_d = gap_q + GAP_W'(1);
                if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            seg_q   <= '0;
            dp_q    <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            gap_q   <= gap_d;
        end
    end

`ifdef DISP_ARB_PREEMPT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    logic unused_tick;
    assign unused_tick = i_tick;
`endif

    assign o_gnt           = gnt_q;
    assign o_six_digit_seg = seg_q;
    assign o_six_dp        = dp_q;
    assign o_busy          = (state_q != IDLE);
    assign o_dbg_state     = state_q;

endmodule

// File: tb/tb_disp_arb.sv
// Directed bench for disp_arb: grant order, gap timing, release/preempt and async reset.
module tb_disp_arb;
    import disp_arb_pkg::*;

    localparam int NR = 3;
    localparam int MH = 4;
    localparam int GC = 2;

    localparam logic [SEG_W-1:0] SEG0 = 42'h0AA;
    localparam logic [SEG_W-1:0] SEG1 = 42'h155;
    localparam logic [SEG_W-1:0] SEG2 = 42'h3A5_5A5A_5A5A;
    localparam logic [DP_W-1:0]  DP0  = 6'h01;
    localparam logic [DP_W-1:0]  DP1  = 6'h2A;
    localparam logic [DP_W-1:0]  DP2  = 6'h15;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  i_tick = 1'b0;
    logic [NR-1:0]         i_req = '0;
    logic [NR*SEG_W-1:0]   i_seg_bus;
    logic [NR*DP_W-1:0]    i_dp_bus;
    logic [NR-1:0]         o_gnt;
    logic [SEG_W-1:0]      o_six_digit_seg;
    logic [DP_W-1:0]       o_six_dp;
    logic                  o_busy;
    state_e                o_dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    disp_arb #(
        .NUM_REQ    (NR),
        .MAX_HOLD   (MH),
        .GAP_CYCLES (GC)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_tick          (i_tick),
        .i_req           (i_req),
        .i_seg_bus       (i_seg_bus),
        .i_dp_bus        (i_dp_bus),
        .o_gnt           (o_gnt),
        .o_six_digit_seg (o_six_digit_seg),
        .o_six_dp        (o_six_dp),
        .o_busy          (o_busy),
        .o_dbg_state     (o_dbg_state)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance n edges; inputs are driven and outputs sampled 1 ns after the edge
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_tick();
        i_tick = 1'b1;
        cyc(1);
        i_tick = 1'b0;
        cyc(1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        i_req = '0;
        i_tick = 1'b0;
        cyc(2);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NR-1:0]    exp_g [4];
        logic [SEG_W-1:0] exp_s [4];
        exp_g = '{3'b001, 3'b010, 3'b100, 3'b001};
        exp_s = '{SEG0, SEG1, SEG2, SEG0};
        i_seg_bus = {SEG2, SEG1, SEG0};
        i_dp_bus  = {DP2, DP1, DP0};

        // Reset state
        do_reset();
        check("rst_gnt", 64'(o_gnt), 64'(0));
        check("rst_seg", 64'(o_six_digit_seg), 64'(0));
        check("rst_dp", 64'(o_six_dp), 64'(0));
        check("rst_busy", 64'(o_busy), 64'(0));
        check("rst_state", 64'(o_dbg_state), 64'(IDLE));

        // Single request from requester 1; data lags the grant by one cycle
        i_req = 3'b010;
        cyc(1);
        check("t1_gnt", 64'(o_gnt), 64'(3'b010));
        check("t1_seg_lag", 64'(o_six_digit_seg), 64'(0));
        check("t1_busy", 64'(o_busy), 64'(1));
        cyc(1);
        check("t1_seg", 64'(o_six_digit_seg), 64'(SEG1));
        check("t1_dp", 64'(o_six_dp), 64'(DP1));

        // Release -> two blank GAP cycles -> IDLE -> pick wraps from pointer 2 to 0
        i_req = 3'b000;
        cyc(1);
        check("t2_gap_gnt", 64'(o_gnt), 64'(0));
        check("t2_gap_seg", 64'(o_six_digit_seg), 64'(0));
        check("t2_gap_busy", 64'(o_busy), 64'(1));
        check("t2_gap_st0", 64'(o_dbg_state), 64'(GAP));
        i_req = 3'b011;
        cyc(1);
        check("t2_gap_st1", 64'(o_dbg_state), 64'(GAP));
        check("t2_gap_gnt1", 64'(o_gnt), 64'(0));
        cyc(1);
        check("t2_idle_st", 64'(o_dbg_state), 64'(IDLE));
        check("t2_idle_busy", 64'(o_busy), 64'(0));
        cyc(1);
        check("t2_wrap_gnt", 64'(o_gnt), 64'(3'b001));
        i_req = 3'b010;
        cyc(3);
        check("t2_idle2", 64'(o_dbg_state), 64'(IDLE));
        cyc(1);
        check("t2_regrant", 64'(o_gnt), 64'(3'b010));
        i_req = 3'b000;
        cyc(3);

        // All three requesting: release after 3 ticks gives 001,010,100,001
        do_reset();
        i_req = 3'b111;
        cyc(1);
        for (int r = 0; r < 4; r++) begin
            check($sformatf("t3_gnt%0d", r), 64'(o_gnt), 64'(exp_g[r]));
            pulse_tick();
            pulse_tick();
            pulse_tick();
            check($sformatf("t3_seg%0d", r), 64'(o_six_digit_seg), 64'(exp_s[r]));
            i_req = 3'b111 & ~exp_g[r];
            cyc(1);
            i_req = 3'b111;
            cyc(3);
        end

        // Owner 0 holds while requester 2 waits
        do_reset();
        i_req = 3'b001;
        cyc(1);
        check("t4_gnt0", 64'(o_gnt), 64'(3'b001));
        i_req = 3'b101;
`ifdef DISP_ARB_PREEMPT_EN
        pulse_tick();
        pulse_tick();
        pulse_tick();
        check("t4_pre3", 64'(o_gnt), 64'(3'b001));
        i_tick = 1'b1;
        cyc(1);
        i_tick = 1'b0;
        check("t4_pre4", 64'(o_gnt), 64'(3'b001));
        cyc(1);
        check("t4_revoked", 64'(o_gnt), 64'(0));
        check("t4_rev_st", 64'(o_dbg_state), 64'(GAP));
        cyc(3);
        check("t4_next", 64'(o_gnt), 64'(3'b100));
`else
        for (int t = 0; t < 20; t++) begin
            pulse_tick();
            check($sformatf("t4_hold%0d", t), 64'(o_gnt), 64'(3'b001));
        end
        i_req = 3'b100;
        cyc(1);
        check("t4_rel", 64'(o_gnt), 64'(0));
        cyc(3);
        check("t4_next", 64'(o_gnt), 64'(3'b100));
`endif

        // Release on the same cycle the hold limit is reached: one GAP, pointer = 1
        do_reset();
        i_req = 3'b001;
        cyc(1);
        check("t5_gnt0", 64'(o_gnt), 64'(3'b001));
        i_req = 3'b101;
        pulse_tick();
        pulse_tick();
        pulse_tick();
        i_tick = 1'b1;
        cyc(1);
        i_tick = 1'b0;
        check("t5_at_max", 64'(o_gnt), 64'(3'b001));
        i_req = 3'b100;
        cyc(1);
        check("t5_gap0", 64'(o_dbg_state), 64'(GAP));
        check("t5_gap_gnt", 64'(o_gnt), 64'(0));
        i_req = 3'b101;
        cyc(1);
        check("t5_gap1", 64'(o_dbg_state), 64'(GAP));
        cyc(1);
        check("t5_idle", 64'(o_dbg_state), 64'(IDLE));
        cyc(1);
        check("t5_next", 64'(o_gnt), 64'(3'b100));
        cyc(1);
        check("t5_seg2", 64'(o_six_digit_seg), 64'(SEG2));
        check("t5_dp2", 64'(o_six_dp), 64'(DP2));

        // Asynchronous reset in the middle of OWN
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_gnt", 64'(o_gnt), 64'(0));
        check("t6_seg", 64'(o_six_digit_seg), 64'(0));
        check("t6_dp", 64'(o_six_dp), 64'(0));
        check("t6_busy", 64'(o_busy), 64'(0));
        check("t6_state", 64'(o_dbg_state), 64'(IDLE));
        cyc(1);
        rst_n = 1'b1;
        i_req = 3'b110;
        cyc(1);
        check("t6_gnt_after", 64'(o_gnt), 64'(3'b010));
        cyc(1);
        check("t6_seg_after", 64'(o_six_digit_seg), 64'(SEG1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
